// File: rtl/mem_pkg.sv
// rtl/mem_pkg.sv - shared types and constants for the refill memory arbiter
package mem_pkg;

    localparam int BLOCK_SIZE = 8;

    typedef enum logic [1:0] {
        ARB_IDLE,
        ARB_GRANT_I,
        ARB_GRANT_D,
        ARB_RELEASE
    } arb_state_t;

    typedef enum logic {
        SRC_I,
        SRC_D
    } arb_src_t;

endpackage

// File: rtl/burst_counter.sv
// rtl/burst_counter.sv - beat counter for one refill burst; saturates at BLOCK_SIZE
module burst_counter #(
    parameter int BLOCK_SIZE = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic inc,
    output logic last,
    output logic done
);

    localparam int CNT_W = $clog2(BLOCK_SIZE + 1);

    logic [CNT_W-1:0] beat_cnt_q;
    logic [CNT_W-1:0] beat_cnt_d;

    assign last = (beat_cnt_q == CNT_W'(BLOCK_SIZE - 1));
    assign done = (beat_cnt_q == CNT_W'(BLOCK_SIZE));

    // Holding at BLOCK_SIZE keeps the count from wrapping back into a live burst.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        if (clr) begin
            beat_cnt_d = '0;
        end else if (inc && !done) begin
            beat_cnt_d = beat_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            beat_cnt_q <= '0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - shares one refill memory port between icache and dcache bursts
module mem_arbiter #(
    parameter int BLOCK_SIZE = mem_pkg::BLOCK_SIZE,
    parameter int ADDR_W     = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [31:0]       i_rdata,
    output logic              i_val,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [31:0]       d_wdata,
    output logic [31:0]       d_rdata,
    output logic              d_val,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    input  logic [31:0]       mem_rdata,
    input  logic              mem_val,
    output logic              busy,
    output logic              mem_err
);

    import mem_pkg::*;

    arb_state_t        state_q, state_d;
    arb_src_t          last_served_q, last_served_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              we_q, we_d;
    logic              mem_err_q, mem_err_d;

    logic grant_i;
    logic grant_d;
    logic granted;
    logic cnt_clr;
    logic cnt_inc;
    logic cnt_last;
    logic cnt_done;

    assign grant_i = (state_q == ARB_GRANT_I);
    assign grant_d = (state_q == ARB_GRANT_D);
    assign granted = grant_i || grant_d;
    assign cnt_inc = granted && mem_val;

    burst_counter #(
        .BLOCK_SIZE (BLOCK_SIZE)
    ) u_burst_counter (
        .clk   (clk),
        .reset (reset),
        .clr   (cnt_clr),
        .inc   (cnt_inc),
        .last  (cnt_last),
        .done  (cnt_done)
    );

    always_comb begin
        state_d       = state_q;
        last_served_d = last_served_q;
        addr_d        = addr_q;
        we_d          = we_q;
        mem_err_d     = mem_err_q;
        cnt_clr       = 1'b0;

        case (state_q)
            ARB_IDLE: begin
                // On a tie the requester served last time yields.
                if (i_req && (!d_req || last_served_q == SRC_D)) begin
                    state_d       = ARB_GRANT_I;
                    last_served_d = SRC_I;
                    addr_d        = i_addr;
                    we_d          = 1'b0;
                    cnt_clr       = 1'b1;
                end else if (d_req) begin
                    state_d       = ARB_GRANT_D;
                    last_served_d = SRC_D;
                    addr_d        = d_addr;
                    we_d          = d_we;
                    cnt_clr       = 1'b1;
                end
            end
            ARB_GRANT_I, ARB_GRANT_D: begin
                if (cnt_done || (mem_val && cnt_last)) begin
                    state_d = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                state_d = ARB_IDLE;
            end
            default: begin
                state_d = ARB_IDLE;
            end
        endcase

        // A beat with no owner means memory and arbiter disagree; keep the evidence.
        if (mem_val && !granted) begin
            mem_err_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ARB_IDLE;
            last_served_q <= SRC_D;
            addr_q        <= '0;
            we_q          <= 1'b0;
            mem_err_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            last_served_q <= last_served_d;
            addr_q        <= addr_d;
            we_q          <= we_d;
            mem_err_q     <= mem_err_d;
        end
    end

    assign mem_req   = granted;
    assign mem_we    = we_q;
    assign mem_addr  = addr_q;
    assign mem_wdata = grant_d ? d_wdata : 32'h0;
    assign i_rdata   = grant_i ? mem_rdata : 32'h0;
    assign d_rdata   = grant_d ? mem_rdata : 32'h0;
    assign i_val     = grant_i && mem_val;
    assign d_val     = grant_d && mem_val;
    assign busy      = (state_q != ARB_IDLE);
    assign mem_err   = mem_err_q;

endmodule
